twiddle_seq_stage_4: RTL and testbench

Stage-4 twiddle sequencer for the 16-point radix-2 DIF CORDIC FFT. It accepts butterfly outputs as a valid/ready stream and tracks each sample's position in the frame. It reads the matching rotation angle from the stage-4 angle ROM and presents sample plus angle, aligned, to the downstream CORDIC rotator. It is the reading end of the angle ROM: it owns address generation, compensates the ROM's one-cycle read latency and keeps alignment under backpressure.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/rom_stage_4.sv | 32 +++
 rtl/twiddle_seq_stage_4.sv | 83 ++++++++
 tb/tb_twiddle_seq_stage_4.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the 16-point radix-2 DIF CORDIC FFT.
// Holds frame geometry, the stage-4 angle ROM shape and the sequencer holding-register layout.
package fft_pkg;

    localparam int DATA_W    = 32;
    localparam int FRAME_LEN = 16;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int ROM_DEPTH = FRAME_LEN / 2;
    localparam int ROM_AW    = $clog2(ROM_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic              valid;
        cplx_t             smp;
        logic [IDX_W-1:0]  idx;
        logic [ROM_AW-1:0] addr;
        logic              rot;
        logic              last;
    } hold_t;

    // Lower half of the frame needs no rotation and shares entry 0 (angle 0).
    function automatic logic [ROM_AW-1:0] angle_addr(input logic [IDX_W-1:0] idx);
        return idx[IDX_W-1] ? idx[ROM_AW-1:0] : '0;
    endfunction

endpackage

// File: rtl/rom_stage_4.sv
// Stage-4 angle ROM: entry k holds -k*pi/8 in Q16.16, one-cycle registered read.
// No handshake; the reader re-presents the address to hold the output stable.
module rom_stage_4
    import fft_pkg::*;
(
    input  logic              i_clk,
    input  logic [ROM_AW-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] rd_val;

    always_comb begin
        rd_val = '0;
        case (i_addr)
            3'd0: rd_val = 32'h0000_0000;
            3'd1: rd_val = 32'hFFFF_9B78;
            3'd2: rd_val = 32'hFFFF_36F0;
            3'd3: rd_val = 32'hFFFE_D268;
            3'd4: rd_val = 32'hFFFE_6DE0;
            3'd5: rd_val = 32'hFFFE_0958;
            3'd6: rd_val = 32'hFFFD_A4D0;
            3'd7: rd_val = 32'hFFFD_4049;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        o_data <= rd_val;
    end

endmodule

// File: rtl/twiddle_seq_stage_4.sv
// Stage-4 twiddle sequencer: pairs each sample with its ROM angle, 1-cycle latency.
// Single holding register; o_ready = !held || i_ready, ROM re-reads the held address during stalls.
module twiddle_seq_stage_4
    import fft_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_re,
    input  logic [DATA_W-1:0] i_im,
    input  logic              i_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_re,
    output logic [DATA_W-1:0] o_im,
    output logic [DATA_W-1:0] o_angle,
    output logic              o_rot,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_last,
    output logic              o_sync_err
);

    logic [IDX_W-1:0]  cnt;
    hold_t             h;
    logic              in_acc;
    logic              cnt_is_end;
    logic              sync_err_q;
    logic [ROM_AW-1:0] rom_addr;

    assign o_ready    = !h.valid || i_ready;
    assign in_acc     = i_valid && o_ready;
    assign cnt_is_end = (cnt == IDX_W'(FRAME_LEN - 1));

    // The ROM is addressed with whatever H will hold after this edge, so its
    // registered output lines up with H; reset parks it on entry 0.
    always_comb begin
        rom_addr = h.addr;
        if (!i_rst_n) begin
            rom_addr = '0;
        end else if (in_acc) begin
            rom_addr = angle_addr(cnt);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt        <= '0;
            h          <= '0;
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= in_acc && (i_last != cnt_is_end);
            if (in_acc) begin
                h.valid  <= 1'b1;
                h.smp.re <= i_re;
                h.smp.im <= i_im;
                h.idx    <= cnt;
                h.addr   <= angle_addr(cnt);
                h.rot    <= cnt[IDX_W-1];
                h.last   <= cnt_is_end;
                // An early i_last restarts the frame; a missing one just wraps.
                cnt      <= (i_last && !cnt_is_end) ? '0 : cnt + IDX_W'(1);
            end else if (i_ready) begin
                h.valid  <= 1'b0;
            end
        end
    end

    rom_stage_4 u_rom (
        .i_clk  (i_clk),
        .i_addr (rom_addr),
        .o_data (o_angle)
    );

    assign o_valid    = h.valid;
    assign o_re       = h.smp.re;
    assign o_im       = h.smp.im;
    assign o_idx      = h.idx;
    assign o_rot      = h.rot;
    assign o_last     = h.last;
    assign o_sync_err = sync_err_q;

endmodule

// File: tb/tb_twiddle_seq_stage_4.sv
// Directed bench for twiddle_seq_stage_4: streaming, stall, random handshake, resync and reset.
module tb_twiddle_seq_stage_4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_re;
    logic [31:0] i_im;
    logic        i_last;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_re;
    logic [31:0] o_im;
    logic [31:0] o_angle;
    logic        o_rot;
    logic [3:0]  o_idx;
    logic        o_last;
    logic        o_sync_err;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] exp_ang [16];

    always #5 i_clk = ~i_clk;

    twiddle_seq_stage_4 dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_re       (i_re),
        .i_im       (i_im),
        .i_last     (i_last),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_re       (o_re),
        .o_im       (o_im),
        .o_angle    (o_angle),
        .o_rot      (o_rot),
        .o_idx      (o_idx),
        .o_last     (o_last),
        .o_sync_err (o_sync_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] smp_re(input int k);
        return 32'h0001_0000 * k + 32'h0000_1234;
    endfunction

    // Drive one sample with the rotator ready, then check the beat it produces.
    task automatic push(input int k, input logic last, input logic exp_err);
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_re    = smp_re(k);
        i_im    = ~smp_re(k);
        i_last  = last;
        @(negedge i_clk);
        chk("valid", 32'(o_valid), 32'd1);
        chk("idx",   32'(o_idx), 32'(k));
        chk("angle", o_angle, exp_ang[k]);
        chk("rot",   32'(o_rot), 32'(k >= 8));
        chk("last",  32'(o_last), 32'(k == 15));
        chk("re",    o_re, smp_re(k));
        chk("serr",  32'(o_sync_err), 32'(exp_err));
    endtask

    initial begin
        logic [35:0] q [$];
        logic [35:0] e;
        logic [3:0]  mcnt;
        int sent;
        int outs;
        int cyc;

        exp_ang = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h0, 32'hFFFF9B78, 32'hFFFF36F0, 32'hFFFED268,
                    32'hFFFE6DE0, 32'hFFFE0958, 32'hFFFDA4D0, 32'hFFFD4049};

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_re    = '0;
        i_im    = '0;
        i_last  = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_serr",  32'(o_sync_err), 32'd0);
        chk("rst_angle", o_angle, 32'd0);
        chk("rst_idx",   32'(o_idx), 32'd0);
        chk("rst_re",    o_re, 32'd0);
        chk("rst_last",  32'(o_last), 32'd0);

        // Full frame back to back.
        for (int k = 0; k < 16; k++) push(k, k == 15, 1'b0);

        // Stall while holding index 10.
        for (int k = 0; k <= 10; k++) push(k, 1'b0, 1'b0);
        i_valid = 1'b0;
        i_ready = 1'b0;
        #1;
        chk("stall_ready", 32'(o_ready), 32'd0);
        for (int s = 0; s < 5; s++) begin
            @(negedge i_clk);
            chk("stall_valid", 32'(o_valid), 32'd1);
            chk("stall_angle", o_angle, 32'hFFFF36F0);
            chk("stall_idx",   32'(o_idx), 32'd10);
            chk("stall_re",    o_re, smp_re(10));
            chk("stall_im",    o_im, ~smp_re(10));
            chk("stall_ready", 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("drain_valid", 32'(o_valid), 32'd0);
        for (int k = 11; k < 16; k++) push(k, k == 15, 1'b0);

        // Early i_last at index 5 restarts the frame.
        for (int k = 0; k < 5; k++) push(k, 1'b0, 1'b0);
        push(5, 1'b1, 1'b1);
        for (int k = 0; k < 16; k++) push(k, k == 15, 1'b0);
        i_valid = 1'b0;

        // Random handshakes over four frames against a scoreboard.
        mcnt = '0;
        sent = 0;
        outs = 0;
        cyc  = 0;
        while ((sent < 64 || q.size() != 0) && cyc < 3000) begin
            @(negedge i_clk);
            cyc++;
            i_valid = (sent < 64) && ($urandom_range(0, 3) != 0);
            i_ready = (sent >= 64) || ($urandom_range(0, 2) != 0);
            i_re    = $urandom;
            i_im    = $urandom;
            i_last  = (mcnt == 4'd15);
            #1;
            if (o_valid && i_ready) begin
                chk("sb_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    outs++;
                    chk("sb_idx",   32'(o_idx), 32'(e[35:32]));
                    chk("sb_re",    o_re, e[31:0]);
                    chk("sb_angle", o_angle, exp_ang[e[35:32]]);
                    chk("sb_serr",  32'(o_sync_err), 32'd0);
                end
            end
            if (i_valid && o_ready) begin
                q.push_back({mcnt, i_re});
                mcnt = mcnt + 4'd1;
                sent++;
            end
        end
        i_valid = 1'b0;
        chk("sb_timeout", 32'(cyc < 3000), 32'd1);
        chk("sb_count",   32'(outs), 32'd64);
        chk("sb_left",    32'(q.size()), 32'd0);
        @(negedge i_clk);

        // Reset while index 11 is held.
        for (int k = 0; k <= 11; k++) push(k, 1'b0, 1'b0);
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("mrst_valid", 32'(o_valid), 32'd0);
        chk("mrst_ready", 32'(o_ready), 32'd1);
        chk("mrst_angle", o_angle, 32'd0);
        @(negedge i_clk);
        push(0, 1'b0, 1'b0);
        i_valid = 1'b0;
        @(negedge i_clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
